icache_fill_unit: RTL and testbench

// Miss-fill stage directly downstream of the instruction cache. Captures the cache's line-fill

---
 rtl/icache_fill_unit.sv | 172 +++++++++++++++++
 tb/tb_icache_fill_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_unit.sv
// Instruction-cache miss-fill unit.
// Queues line-fill requests from the icache in an in-order FIFO, issues them one at a time to
// main memory over a valid/ready request channel, waits for each single-cycle response and hands
// the filled line back to the icache as a one-cycle rec pulse.
module icache_fill_unit #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1),
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 512
) (
  input  logic              clk,
  input  logic              rst,
  // icache side
  input  logic              ic_req_ren,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_rec_en,
  output logic [ADDR_W-1:0] ic_rec_addr,
  output logic [LINE_W-1:0] ic_rec_line,
  // main memory side
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_line,
  // status
  output logic [CNT_W-1:0]  occupancy,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PtrLast  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CntFull  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] rec_addr_q, rec_addr_d;
  logic [LINE_W-1:0] rec_line_q, rec_line_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] head_addr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntFull);
  assign head_addr  = fifo_mem[rd_ptr_q];

  // A full FIFO still accepts a request when the head is being popped in the same cycle.
  assign push = ic_req_ren && (!fifo_full || pop);

  // FIFO pointer, occupancy and sticky-overflow next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ic_req_ren && !push) begin
      overflow_d = 1'b1;
    end
  end

  // Request storage; contents are don't-care while the pointers say empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ic_req_addr;
    end
  end

  // Fill FSM next state and outputs: one memory transaction in flight, returned in order.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    cur_addr_d    = cur_addr_q;
    rec_addr_d    = rec_addr_q;
    rec_line_d    = rec_line_q;
    mem_req_valid = 1'b0;
    ic_rec_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_addr_d = head_addr;
          state_d    = StReq;
        end
      end
      StReq: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rsp_valid) begin
          rec_addr_d = cur_addr_q;
          rec_line_d = mem_rsp_line;
          state_d    = StResp;
        end
      end
      StResp: begin
        ic_rec_en = 1'b1;
        // Pop straight into the next request so back-to-back fills have no idle bubble.
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_addr_d = head_addr;
          state_d    = StReq;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; reset drops queue and in-flight fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cur_addr_q <= '0;
      rec_addr_q <= '0;
      rec_line_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cur_addr_q <= cur_addr_d;
      rec_addr_q <= rec_addr_d;
      rec_line_q <= rec_line_d;
    end
  end

  // cur_addr only changes on a pop, so the request address is stable throughout REQ.
  assign mem_req_addr = cur_addr_q;
  assign ic_rec_addr  = rec_addr_q;
  assign ic_rec_line  = rec_line_q;
  assign occupancy    = count_q;
  assign busy         = (state_q != StIdle) || !fifo_empty;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_icache_fill_unit.sv
// Directed testbench for icache_fill_unit (FIFO_DEPTH=4).
module tb_icache_fill_unit;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 512;

  logic              clk;
  logic              rst;
  logic              ic_req_ren;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_rec_en;
  logic [ADDR_W-1:0] ic_rec_addr;
  logic [LINE_W-1:0] ic_rec_line;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_line;
  logic [CNT_W-1:0]  occupancy;
  logic              busy;
  logic              overflow;

  int tests;
  int fails;

  icache_fill_unit #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CNT_W),
    .ADDR_W    (ADDR_W),
    .LINE_W    (LINE_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_req_ren   (ic_req_ren),
    .ic_req_addr  (ic_req_addr),
    .ic_rec_en    (ic_rec_en),
    .ic_rec_addr  (ic_rec_addr),
    .ic_rec_line  (ic_rec_line),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_line (mem_rsp_line),
    .occupancy    (occupancy),
    .busy         (busy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {16{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_ren    = 1'b0;
    ic_req_addr   = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_line  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    ic_req_ren    = 1'b1;
    ic_req_addr   = 32'h0000_1000;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_line  = {16{32'hFFFF_FFFF}};
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({ic_rec_en, mem_req_valid, busy, overflow, occupancy} !== 7'b0) begin
        $display("FAIL reset_flags cyc%0d: got %b want 0", c,
                 {ic_rec_en, mem_req_valid, busy, overflow, occupancy});
        fails++;
      end
      tests++;
      if (ic_rec_addr !== 32'h0 || mem_req_addr !== 32'h0 || ic_rec_line !== '0) begin
        $display("FAIL reset_data cyc%0d: rec_addr %h req_addr %h want 0", c, ic_rec_addr,
                 mem_req_addr);
        fails++;
      end
    end
    rst = 1'b1;
    idle_inputs();
    step();
    tests++;
    if ({ic_rec_en, mem_req_valid, busy, overflow, occupancy} !== 7'b0) begin
      $display("FAIL reset_release: got %b want 0",
               {ic_rec_en, mem_req_valid, busy, overflow, occupancy});
      fails++;
    end
  endtask

  task automatic test_single();
    logic [LINE_W-1:0] line_a5;
    line_a5      = {16{32'hA5A5_A5A5}};
    ic_req_ren   = 1'b1;
    ic_req_addr  = 32'h0000_1040;
    mem_rsp_line = line_a5;
    for (int c = 1; c <= 8; c++) begin
      step();
      ic_req_ren    = 1'b0;
      mem_req_ready = (c == 2);
      mem_rsp_valid = (c == 5);
      tests++;
      if (mem_req_valid !== (c == 2)) begin
        $display("FAIL single_req_valid N+%0d: got %b want %b", c, mem_req_valid, (c == 2));
        fails++;
      end
      tests++;
      if (ic_rec_en !== (c == 6)) begin
        $display("FAIL single_rec_en N+%0d: got %b want %b", c, ic_rec_en, (c == 6));
        fails++;
      end
      if (c == 2) begin
        tests++;
        if (mem_req_addr !== 32'h0000_1040) begin
          $display("FAIL single_req_addr: got %h want 00001040", mem_req_addr);
          fails++;
        end
      end
      if (c == 6 || c == 8) begin
        tests++;
        if (ic_rec_addr !== 32'h0000_1040 || ic_rec_line !== line_a5) begin
          $display("FAIL single_rec_data N+%0d: addr %h want 00001040 line[31:0] %h want a5a5a5a5",
                   c, ic_rec_addr, ic_rec_line[31:0]);
          fails++;
        end
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL single_busy_end: got %b want 0", busy);
      fails++;
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int hs;
    hs           = 0;
    ic_req_ren   = 1'b1;
    ic_req_addr  = 32'h0000_2080;
    mem_rsp_line = line_of(32'h0000_2080);
    for (int c = 1; c <= 10; c++) begin
      step();
      ic_req_ren    = 1'b0;
      mem_req_ready = (c == 6);
      mem_rsp_valid = (c == 8);
      if (mem_req_valid && mem_req_ready) hs++;
      tests++;
      if (mem_req_valid !== (c >= 2 && c <= 6)) begin
        $display("FAIL bp_valid N+%0d: got %b want %b", c, mem_req_valid, (c >= 2 && c <= 6));
        fails++;
      end
      if (c >= 2 && c <= 6) begin
        tests++;
        if (mem_req_addr !== 32'h0000_2080) begin
          $display("FAIL bp_addr_stable N+%0d: got %h want 00002080", c, mem_req_addr);
          fails++;
        end
      end
      tests++;
      if (ic_rec_en !== (c == 9)) begin
        $display("FAIL bp_rec_en N+%0d: got %b want %b", c, ic_rec_en, (c == 9));
        fails++;
      end
    end
    tests++;
    if (hs != 1) begin
      $display("FAIL bp_handshakes: got %0d want 1", hs);
      fails++;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] exp_addr [5];
    int   k;
    int   peak;
    logic prev_rec;
    for (int i = 0; i < 5; i++) exp_addr[i] = ADDR_W'((i + 1) * 32'h100);
    k        = 0;
    peak     = 0;
    prev_rec = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ic_req_ren    = (c < 5);
      ic_req_addr   = (c < 5) ? exp_addr[c] : '0;
      mem_req_ready = (c >= 5);
      mem_rsp_valid = 1'b1;
      mem_rsp_line  = line_of(mem_req_addr);
      step();
      if (int'(occupancy) > peak) peak = int'(occupancy);
      if (prev_rec && k < 5) begin
        tests++;
        if (mem_req_valid !== 1'b1) begin
          $display("FAIL b2b_no_bubble after rec %0d: valid %b want 1", k, mem_req_valid);
          fails++;
        end
      end
      if (ic_rec_en) begin
        tests++;
        if (k >= 5) begin
          $display("FAIL b2b_extra_rec: got rec %0d want 5 total", k + 1);
          fails++;
        end else if (ic_rec_addr !== exp_addr[k] || ic_rec_line !== line_of(exp_addr[k])) begin
          $display("FAIL b2b_order rec %0d: addr %h want %h", k, ic_rec_addr, exp_addr[k]);
          fails++;
        end
        k++;
      end
      prev_rec = ic_rec_en;
    end
    tests++;
    if (k != 5) begin
      $display("FAIL b2b_rec_count: got %0d want 5", k);
      fails++;
    end
    tests++;
    if (peak != 4) begin
      $display("FAIL b2b_peak_occupancy: got %0d want 4", peak);
      fails++;
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] exp_addr [6];
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) exp_addr[i] = 32'h0000_0A00 + ADDR_W'(i * 32'h40);
    for (int c = 0; c < 8; c++) begin
      ic_req_ren  = (c < 6);
      ic_req_addr = (c < 6) ? exp_addr[c] : '0;
      step();
    end
    tests++;
    if (occupancy !== 3'd4 || overflow !== 1'b1 || mem_req_valid !== 1'b1) begin
      $display("FAIL ovf_state: occ %0d ovf %b valid %b want 4 1 1", occupancy, overflow,
               mem_req_valid);
      fails++;
    end
    tests++;
    if (mem_req_addr !== exp_addr[0]) begin
      $display("FAIL ovf_inflight_addr: got %h want %h", mem_req_addr, exp_addr[0]);
      fails++;
    end
    n = 0;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_line  = line_of(mem_req_addr);
      if (mem_req_valid) begin
        tests++;
        if (n >= 5 || mem_req_addr !== exp_addr[n]) begin
          $display("FAIL ovf_issue %0d: got %h want %h", n, mem_req_addr,
                   (n < 5) ? exp_addr[n] : 32'hFFFF_FFFF);
          fails++;
        end
        n++;
      end
      step();
    end
    tests++;
    if (n != 5 || overflow !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL ovf_end: issued %0d ovf %b busy %b want 5 1 0", n, overflow, busy);
      fails++;
    end
    idle_inputs();
    do_reset();
    step();
    tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_cleared_by_reset: got %b want 0", overflow);
      fails++;
    end
  endtask

  task automatic test_simul_and_reset();
    do_reset();
    ic_req_ren  = 1'b1;
    ic_req_addr = 32'h0000_3000;
    step();
    tests++;
    if (occupancy !== 3'd1) begin
      $display("FAIL simul_occ_before: got %0d want 1", occupancy);
      fails++;
    end
    ic_req_addr = 32'h0000_3040;
    step();
    tests++;
    if (occupancy !== 3'd1 || overflow !== 1'b0) begin
      $display("FAIL simul_occ_after: occ %0d ovf %b want 1 0", occupancy, overflow);
      fails++;
    end
    tests++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_3000) begin
      $display("FAIL simul_req: valid %b addr %h want 1 00003000", mem_req_valid, mem_req_addr);
      fails++;
    end
    ic_req_ren    = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    tests++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL simul_wait: valid %b busy %b want 0 1", mem_req_valid, busy);
      fails++;
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    tests++;
    if (occupancy !== 3'd0 || busy !== 1'b0) begin
      $display("FAIL rst_wait_clear: occ %0d busy %b want 0 0", occupancy, busy);
      fails++;
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_line  = line_of(32'h0000_3000);
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if (ic_rec_en !== 1'b0 || mem_req_valid !== 1'b0) begin
        $display("FAIL rst_stale_rsp cyc%0d: rec_en %b valid %b want 0 0", c, ic_rec_en,
                 mem_req_valid);
        fails++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_simul_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
